// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared controller types for the pipeline hazard sequencer: per-stage control
// record, sequencer state encoding and a small stage-index helper.
package pipeline_hazard_sequencer_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef struct packed {
        logic stall;
        logic flush;
    } StageCtrl;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_WAIT  = 2'd1,
        BR_FLUSH = 2'd2,
        REFILL   = 2'd3
    } PipeSeqState;

    // A resolving stage beyond the last register means "flush everything".
    function automatic int clampStage(input int stage, input int maxStage);
        if (stage > maxStage) begin
            return maxStage;
        end else begin
            return stage;
        end
    endfunction

endpackage

// File: rtl/pipeline_hazard_sequencer_counter.sv
// Saturating event counter used for the sequencer performance statistics.
// Clear takes priority over increment; the value sticks at all-ones.
module sat_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Counter register with synchronous clear and saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Central stall/flush sequencer for an in-order pipeline: merges stall requests,
// branch-wait sequencing and redirect refill. Optional perf counters: PIPE_SEQ_PERF_EN.
module pipeline_hazard_sequencer
    import pipeline_hazard_sequencer_pkg::*;
#(
    parameter int STAGE_NUM        = 4,
    parameter int REDIRECT_PENALTY = 2,
    parameter int MULDIV_STAGE     = 2
`ifdef PIPE_SEQ_PERF_EN
    ,
    parameter int PERF_WIDTH       = 32
`endif
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [STAGE_NUM-1:0]             stallReq,
    input  logic                             redirect,
    input  logic [$clog2(STAGE_NUM+1)-1:0]   redirectStage,
    input  logic                             branchHazard,
    input  logic                             branchResolved,
    output StageCtrl [STAGE_NUM-1:0]         stageCtrl,
    output logic                             mulDivClear,
    output logic                             fetchBlocked
`ifdef PIPE_SEQ_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0]            perfStallCycles,
    output logic [PERF_WIDTH-1:0]            perfRedirects,
    input  logic                             perfClear
`endif
);

    localparam int CNT_W = (REDIRECT_PENALTY > 1) ? $clog2(REDIRECT_PENALTY) : 1;

    PipeSeqState              state_r, nextState_s;
    logic [CNT_W-1:0]         refillCnt_r, nextCnt_s;
    logic                     pendHazard_r, nextPendHz_s;
    logic                     pendResolved_r, nextPendRes_s;
    StageCtrl [STAGE_NUM-1:0] ctrl_s;
    logic                     mulDivClear_s;
    int                       hiIdx_s;
    int                       rsClamped_s;
    logic                     waitPending_s;
    logic                     hazardEff_s;
    logic                     resolvedEff_s;

    assign rsClamped_s   = clampStage(int'(redirectStage), STAGE_NUM);
    assign hazardEff_s   = branchHazard | pendHazard_r;
    assign resolvedEff_s = branchResolved | pendResolved_r;
    // A resolve only matters while some branch is (or is about to be) waited on.
    assign waitPending_s = (state_r == BR_WAIT) | pendHazard_r |
                           (branchHazard & (state_r != REFILL));

    // Highest stalled stage: everything younger is held, it gets a bubble.
    always_comb begin
        hiIdx_s = 0;
        for (int i = 0; i < STAGE_NUM; i++) begin
            if (stallReq[i]) begin
                hiIdx_s = i;
            end else begin
                hiIdx_s = hiIdx_s;
            end
        end
    end

    // Priority resolution: redirect, then stall requests, then the FSM.
    always_comb begin
        ctrl_s        = '0;
        mulDivClear_s = FALSE;
        nextState_s   = state_r;
        nextCnt_s     = refillCnt_r;
        nextPendHz_s  = pendHazard_r;
        nextPendRes_s = pendResolved_r;
        if (redirect) begin
            for (int i = 0; i < STAGE_NUM; i++) begin
                ctrl_s[i].flush = (i < rsClamped_s);
            end
            mulDivClear_s = (MULDIV_STAGE < rsClamped_s);
            nextPendHz_s  = FALSE;
            nextPendRes_s = FALSE;
            if (REDIRECT_PENALTY == 1) begin
                nextState_s = RUN;
            end else begin
                nextState_s = REFILL;
                nextCnt_s   = CNT_W'(REDIRECT_PENALTY - 1);
            end
        end else if (|stallReq) begin
            for (int i = 0; i < STAGE_NUM; i++) begin
                ctrl_s[i].stall = (i < hiIdx_s);
                ctrl_s[i].flush = (i == hiIdx_s);
            end
            if (branchHazard && ((state_r == RUN) || (state_r == BR_FLUSH))) begin
                nextPendHz_s = TRUE;
            end else begin
                nextPendHz_s = pendHazard_r;
            end
            if (branchResolved && waitPending_s) begin
                nextPendRes_s = TRUE;
            end else begin
                nextPendRes_s = pendResolved_r;
            end
        end else begin
            case (state_r)
                RUN: begin
                    nextPendHz_s  = FALSE;
                    nextPendRes_s = FALSE;
                    if (hazardEff_s) begin
                        ctrl_s[0].stall = TRUE;
                        nextState_s     = resolvedEff_s ? BR_FLUSH : BR_WAIT;
                    end else begin
                        nextState_s = RUN;
                    end
                end
                BR_WAIT: begin
                    ctrl_s[0].stall = TRUE;
                    nextPendHz_s    = FALSE;
                    nextPendRes_s   = FALSE;
                    if (resolvedEff_s) begin
                        nextState_s = BR_FLUSH;
                    end else begin
                        nextState_s = BR_WAIT;
                    end
                end
                BR_FLUSH: begin
                    ctrl_s[0].flush = TRUE;
                    nextPendHz_s    = FALSE;
                    nextPendRes_s   = FALSE;
                    if (hazardEff_s) begin
                        nextState_s = resolvedEff_s ? BR_FLUSH : BR_WAIT;
                    end else begin
                        nextState_s = RUN;
                    end
                end
                REFILL: begin
                    ctrl_s[0].flush = TRUE;
                    nextPendHz_s    = FALSE;
                    nextPendRes_s   = FALSE;
                    if (refillCnt_r == '0) begin
                        nextState_s = RUN;
                    end else begin
                        nextCnt_s = refillCnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    nextState_s   = RUN;
                    nextCnt_s     = '0;
                    nextPendHz_s  = FALSE;
                    nextPendRes_s = FALSE;
                end
            endcase
        end
    end

    // Sequencer state, refill counter and pending branch latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= RUN;
            refillCnt_r    <= '0;
            pendHazard_r   <= FALSE;
            pendResolved_r <= FALSE;
        end else begin
            state_r        <= nextState_s;
            refillCnt_r    <= nextCnt_s;
            pendHazard_r   <= nextPendHz_s;
            pendResolved_r <= nextPendRes_s;
        end
    end

    assign stageCtrl    = rst ? '0 : ctrl_s;
    assign mulDivClear  = rst ? FALSE : mulDivClear_s;
    assign fetchBlocked = rst ? FALSE : (state_r != RUN);

`ifdef PIPE_SEQ_PERF_EN
    logic anyStall_s;

    // Any stall bit this cycle; redirect cycles never stall.
    always_comb begin
        anyStall_s = FALSE;
        for (int i = 0; i < STAGE_NUM; i++) begin
            anyStall_s = anyStall_s | ctrl_s[i].stall;
        end
    end

    sat_perf_counter #(.WIDTH(PERF_WIDTH)) uStallCnt (
        .clk   (clk),
        .rst   (rst),
        .clear (perfClear),
        .inc   (anyStall_s),
        .count (perfStallCycles)
    );

    sat_perf_counter #(.WIDTH(PERF_WIDTH)) uRedirectCnt (
        .clk   (clk),
        .rst   (rst),
        .clear (perfClear),
        .inc   (redirect),
        .count (perfRedirects)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed, table-driven bench for pipeline_hazard_sequencer (STAGE_NUM=4,
// REDIRECT_PENALTY=2, MULDIV_STAGE=2; PERF_WIDTH=4 when PIPE_SEQ_PERF_EN).
module tb_pipeline_hazard_sequencer;
    import pipeline_hazard_sequencer_pkg::*;

    logic           clk;
    logic           rst;
    logic [3:0]     stallReq;
    logic           redirect;
    logic [2:0]     redirectStage;
    logic           branchHazard;
    logic           branchResolved;
    StageCtrl [3:0] stageCtrl;
    logic           mulDivClear;
    logic           fetchBlocked;
`ifdef PIPE_SEQ_PERF_EN
    logic [3:0]     perfStallCycles;
    logic [3:0]     perfRedirects;
    logic           perfClear;
`endif

    pipeline_hazard_sequencer #(
        .STAGE_NUM(4),
        .REDIRECT_PENALTY(2),
        .MULDIV_STAGE(2)
`ifdef PIPE_SEQ_PERF_EN
        ,
        .PERF_WIDTH(4)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .stallReq(stallReq),
        .redirect(redirect),
        .redirectStage(redirectStage),
        .branchHazard(branchHazard),
        .branchResolved(branchResolved),
        .stageCtrl(stageCtrl),
        .mulDivClear(mulDivClear),
        .fetchBlocked(fetchBlocked)
`ifdef PIPE_SEQ_PERF_EN
        ,
        .perfStallCycles(perfStallCycles),
        .perfRedirects(perfRedirects),
        .perfClear(perfClear)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sr;
        logic       rd;
        logic [2:0] rs;
        logic       bh;
        logic       br;
        logic [3:0] expStall;
        logic [3:0] expFlush;
        logic       expMdc;
        logic       expBlk;
    } vec_t;

    vec_t vecs[$];
    int   passCount = 0;
    int   totalChecks = 0;

    function automatic logic [9:0] observed();
        logic [3:0] s;
        logic [3:0] f;
        for (int i = 0; i < 4; i++) begin
            s[i] = stageCtrl[i].stall;
            f[i] = stageCtrl[i].flush;
        end
        return {s, f, mulDivClear, fetchBlocked};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sr, input logic rd, input logic [2:0] rs,
                         input logic bh, input logic br);
        stallReq = sr; redirect = rd; redirectStage = rs;
        branchHazard = bh; branchResolved = br;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] sr, input logic rd, input logic [2:0] rs, input logic bh,
                       input logic br, input logic [3:0] st, input logic [3:0] fl,
                       input logic mdc, input logic blk);
        vecs.push_back('{sr, rd, rs, bh, br, st, fl, mdc, blk});
    endtask

    initial begin
        // sr, rd, rs, bh, br  ->  stall, flush, mulDivClear, fetchBlocked
        // stall request at stage 1 for three cycles
        add(4'b0010, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0001, 4'b0010, 1'b0, 1'b0);
        add(4'b0010, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0001, 4'b0010, 1'b0, 1'b0);
        add(4'b0010, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0001, 4'b0010, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // branch wait: hazard t0, resolve t3, flush t4, RUN t5
        add(4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // redirect from stage 3 into REFILL
        add(4'b0000, 1'b1, 3'd3, 1'b0, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // redirect + stall + branch hazard together: redirect wins, no branch wait
        add(4'b1000, 1'b1, 3'd3, 1'b1, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // redirectStage 0: no flush bits but still refills
        add(4'b0000, 1'b1, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // redirectStage 7 clamps to 4
        add(4'b0000, 1'b1, 3'd7, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // mul/div at stage 2 not cleared by stage-2 redirect; re-redirect reloads counter
        add(4'b0000, 1'b1, 3'd2, 1'b0, 1'b0, 4'b0000, 4'b0011, 1'b0, 1'b0);
        add(4'b0000, 1'b1, 3'd1, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // resolve during a stall is latched and consumed in BR_WAIT
        add(4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0);
        add(4'b0100, 1'b0, 3'd0, 1'b0, 1'b1, 4'b0011, 4'b0100, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // stall freezes the refill counter
        add(4'b0000, 1'b1, 3'd1, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0);
        add(4'b0001, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // stray resolve ignored; hazard+resolve together goes straight to flush
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 3'd0, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // new hazard during BR_FLUSH re-enters BR_WAIT
        add(4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1);
        add(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Reset with every input high: all outputs low.
        rst = 1'b1;
        drive(4'b1111, 1'b1, 3'b111, 1'b1, 1'b1);
`ifdef PIPE_SEQ_PERF_EN
        perfClear = 1'b1;
`endif
        repeat (2) stepCycle();
        check("reset_outputs", {22'd0, observed()}, 32'd0);
`ifdef PIPE_SEQ_PERF_EN
        check("reset_perf", {24'd0, perfStallCycles, perfRedirects}, 32'd0);
        perfClear = 1'b0;
`endif
        drive(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        stepCycle();
        check("release_idle", {22'd0, observed()}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            stepCycle();
            drive(vecs[i].sr, vecs[i].rd, vecs[i].rs, vecs[i].bh, vecs[i].br);
            @(negedge clk);
            check($sformatf("vec%0d", i), {22'd0, observed()},
                  {22'd0, vecs[i].expStall, vecs[i].expFlush, vecs[i].expMdc, vecs[i].expBlk});
        end

        // Reset in the middle of a branch wait abandons it.
        stepCycle();
        drive(4'b0000, 1'b0, 3'd0, 1'b1, 1'b0);
        stepCycle();
        drive(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("midseq_blocked", {31'd0, fetchBlocked}, 32'd1);
        rst = 1'b1;
        #1;
        check("midseq_in_reset", {22'd0, observed()}, 32'd0);
        stepCycle();
        rst = 1'b0;
        @(negedge clk);
        check("midseq_after_reset", {22'd0, observed()}, 32'd0);

`ifdef PIPE_SEQ_PERF_EN
        stepCycle();
        perfClear = 1'b1;
        stepCycle();
        perfClear = 1'b0;
        @(negedge clk);
        check("perf_clear_init", {24'd0, perfStallCycles, perfRedirects}, 32'd0);
        for (int c = 0; c < 20; c++) begin
            stepCycle();
            drive(4'b0001 << (c % 4), 1'b0, 3'd0, 1'b0, 1'b0);
        end
        // one of every four patterns (bit 0) bubbles without stalling: 15 stall cycles
        stepCycle();
        drive(4'b0010, 1'b0, 3'd0, 1'b0, 1'b0);
        stepCycle();
        drive(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("perf_stall_sat", {28'd0, perfStallCycles}, 32'd15);
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            drive(4'b0000, 1'b1, 3'd1, 1'b0, 1'b0);
        end
        stepCycle();
        drive(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("perf_redirects", {28'd0, perfRedirects}, 32'd3);
        stepCycle();
        perfClear = 1'b1;
        drive(4'b0010, 1'b1, 3'd1, 1'b0, 1'b0);
        stepCycle();
        perfClear = 1'b0;
        drive(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("perf_clear_prio", {24'd0, perfStallCycles, perfRedirects}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule
